// File: rtl/fetch_queue.sv
// Fetch front end: PC generation, credit-limited memory requests,
// and a small PC-tagged instruction FIFO with branch flush.
module fetch_queue #(
  parameter int DATA = 32,
  parameter int ADDR = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [ADDR-1:0] mem_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rvalid,
  input  logic [DATA-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [ADDR-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [DATA-1:0] instr,
  output logic [ADDR-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + MAX_OUT + 1) + 1;

  logic [ADDR-1:0] fetch_pc;
  logic [ADDR-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [DATA-1:0] data_q [DEPTH];
  logic [ADDR-1:0] pc_q [DEPTH];

  logic            accept;
  logic            keep;
  logic            pop;
  logic [ADDR-1:0] target;

  // Credits cover both buffered and in-flight words, so a
  // response always finds a free slot.
  always_comb begin
    mem_req = !rst && !redirect
           && (outstanding < CW'(MAX_OUT))
           && ((count + outstanding) < CW'(DEPTH));
    mem_addr    = fetch_pc;
    instr_valid = (count != '0);
    instr       = instr_valid ? data_q[rd_ptr] : '0;
    instr_pc    = instr_valid ? pc_q[rd_ptr] : '0;
    accept      = mem_req && mem_req_ready;
    keep        = mem_rvalid && (drop == '0) && !redirect;
    pop         = instr_valid && instr_ready;
    target      = {redirect_pc[ADDR-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      data_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      // Everything still in flight after this cycle is stale.
      fetch_pc    <= target;
      resp_pc     <= target;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= outstanding - CW'(mem_rvalid);
      drop        <= outstanding - CW'(mem_rvalid);
    end else begin
      if (accept)
        fetch_pc <= fetch_pc + ADDR'(4);
      outstanding <= outstanding + CW'(accept) - CW'(mem_rvalid);
      if (mem_rvalid && (drop != '0))
        drop <= drop - CW'(1);
      if (keep) begin
        resp_pc <= resp_pc + ADDR'(4);
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(keep) - CW'(pop);
    end
  end

endmodule
